// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth step
// operations and the accumulator width helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } op_t;

  // One guard bit keeps -2^(W-1) * -2^(W-1) exact.
  function automatic int acc_w(input int w);
    return w + 1;
  endfunction

  function automatic op_t booth_op(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Start/busy/done handshake and operand/product bus of the Booth multiplier.
interface booth_seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_addsub.sv
// W-bit ripple-carry add/subtract; subtract inverts b and injects carry-in.
module booth_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0]   c;
  logic [W-1:0] b_x;

  assign c[0] = sub;
  assign b_x  = b ^ {W{sub}};

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b_x[i] ^ c[i];
    assign c[i+1]   = (a[i] & b_x[i]) | (c[i] & (a[i] ^ b_x[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Radix-2 sequential Booth multiplier: one add/sub/no-op plus arithmetic
// shift of {A, Q, q_m1} per cycle, WIDTH steps per product.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one Booth step per cycle, cnt counts remaining steps
// DONE  | product valid, done pulse; start here reloads immediately
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_seq_multiplier_if.slave bus
);

  localparam int ACC_W = acc_w(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     m_q, m_d;
  logic [ACC_W-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  op_t                  op;
  logic [ACC_W-1:0]     add_sum;
  logic [ACC_W-1:0]     a_step;
  logic                 add_cout_unused;

  assign op = booth_op(q_q[0], qm1_q);

  booth_addsub #(.W(ACC_W)) u_addsub (
    .a    (a_q),
    .b    (m_q),
    .sub  (op == SUB),
    .sum  (add_sum),
    .cout (add_cout_unused)
  );

  assign a_step = (op == NOP) ? a_q : add_sum;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = CALC;
          busy_d  = 1'b1;
          a_d     = '0;
          q_d     = bus.multiplier;
          qm1_d   = 1'b0;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      CALC: begin
        a_d   = {a_step[ACC_W-1], a_step[ACC_W-1:1]};
        q_d   = {a_step[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          prod_d  = {a_d[WIDTH-1:0], q_d};
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and randomized checks of booth_seq_multiplier against a plain
// signed-multiply reference, including handshake timing and async reset.
module tb_booth_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier_if #(.WIDTH(4)) bus ();

  booth_seq_multiplier #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
    int x;
    int y;
    x = int'($signed(a));
    y = int'($signed(b));
    return 8'(x * y);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits between edges; start is applied for the next rising edge.
  // Returns just after the edge where done rises.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input bit hold, input string tag);
    int n;
    int nb;
    logic [7:0] exp;
    exp              = ref_prod(a, b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk); #1;
    bus.start        = hold;
    bus.multiplicand = 4'($urandom);
    bus.multiplier   = 4'($urandom);
    chk({tag, "_busy_on_start"}, bus.busy, 1);
    nb = bus.busy ? 1 : 0;
    n  = 0;
    while (!bus.done && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy) nb++;
      if (hold && !bus.done) begin
        bus.start        = 1'b1;
        bus.multiplicand = 4'($urandom);
        bus.multiplier   = 4'($urandom);
      end
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 16'(n), 4);
    chk({tag, "_busy_cycles"}, 16'(nb), 4);
    chk({tag, "_product"}, bus.product, exp);
  endtask

  task automatic idle_check(input logic [3:0] a, input logic [3:0] b, input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_held"}, bus.product, ref_prod(a, b));
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    bit         seen_done;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    rst_n            = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_product", bus.product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd3, 4'd5, 0, "basic");
    chk("basic_const", bus.product, 16'h0F);
    idle_check(4'd3, 4'd5, "basic");

    run_op(4'h8, 4'h8, 0, "m8_m8");
    chk("m8_m8_const", bus.product, 16'h40);
    idle_check(4'h8, 4'h8, "m8_m8");
    run_op(4'h8, 4'h7, 0, "m8_7");
    chk("m8_7_const", bus.product, 16'hC8);
    idle_check(4'h8, 4'h7, "m8_7");
    run_op(4'h7, 4'hF, 0, "7_m1");
    chk("7_m1_const", bus.product, 16'hF9);
    idle_check(4'h7, 4'hF, "7_m1");
    run_op(4'h0, 4'hB, 0, "0_m5");
    chk("0_m5_const", bus.product, 16'h00);
    idle_check(4'h0, 4'hB, "0_m5");

    run_op(4'h6, 4'hD, 1, "ignore_busy");
    idle_check(4'h6, 4'hD, "ignore_busy");

    run_op(4'h5, 4'h3, 0, "b2b_first");
    run_op(4'h2, 4'hD, 0, "b2b_second");
    chk("b2b_const", bus.product, 16'hFA);
    idle_check(4'h2, 4'hD, "b2b_second");

    // Reset in the second CALC cycle
    bus.start        = 1'b1;
    bus.multiplicand = 4'h5;
    bus.multiplier   = 4'h3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_product", bus.product, 0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    chk("rst_mid_no_done", seen_done, 0);
    chk("rst_mid_busy_after", bus.busy, 0);
    run_op(4'hC, 4'h3, 0, "after_rst");
    idle_check(4'hC, 4'h3, "after_rst");

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), 0, "exh");
        idle_check(4'(i), 4'(j), "exh");
      end
    end

    for (int k = 0; k < 24; k++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op(ra, rb, bit'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 1) == 0) idle_check(ra, rb, "rand");
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
